// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, defaults and round-robin pick for seq_detect_sched
//
// Contents:
//   state_e      scheduler FSM states
//   DEF_PAT_LEN  default pattern length
//   DEF_PATTERN  default pattern, MSB matched first
//   MAX_REQ      largest requester count rr_winner supports
//   rr_winner()  lowest active request index at or after ptr, wrapping at nreq
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int              DEF_PAT_LEN = 3;
    localparam logic [2:0]      DEF_PATTERN = 3'b101;
    localparam int              MAX_REQ     = 8;

    // Scans offsets from the highest down so the final assignment that sticks
    // is the smallest offset from ptr, i.e. the round-robin winner. Returns
    // ptr when nothing is requesting; callers only use it when |req.
    function automatic int rr_winner(input logic [MAX_REQ-1:0] req,
                                     input int ptr,
                                     input int nreq);
        int idx;
        int win;
        win = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < nreq) begin
                idx = (ptr + i) % nreq;
                if (req[idx[2:0]]) begin
                    win = idx;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bit_pattern_matcher.sv
// rtl/bit_pattern_matcher.sv - serial overlapping pattern matcher with registered hit
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset
//   clr_i        synchronous clear of history, fill count and hit
//   bit_valid_i  ser_bit_i carries a bit this cycle
//   ser_bit_i    serial input bit
//   hit_o        registered: previous valid bit completed PATTERN
module bit_pattern_matcher #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic bit_valid_i,
    input  logic ser_bit_i,
    output logic hit_o
);

    logic hit_q;

    generate
        if (PAT_LEN == 1) begin : g_single
            always_ff @(posedge clk_i) begin
                if (reset_i || clr_i) begin
                    hit_q <= 1'b0;
                end else begin
                    hit_q <= bit_valid_i && (ser_bit_i == PATTERN[0]);
                end
            end
        end else begin : g_multi
            // Only the previous PAT_LEN-1 bits are stored; the incoming bit
            // completes the PAT_LEN-bit window for the compare.
            localparam int FILL_W = $clog2(PAT_LEN);

            logic [PAT_LEN-2:0] hist_q;
            logic [FILL_W-1:0]  fill_q;
            logic [PAT_LEN-1:0] window;
            logic               full;

            assign window = {hist_q, ser_bit_i};
            assign full   = (fill_q >= FILL_W'(PAT_LEN - 1));

            always_ff @(posedge clk_i) begin
                if (reset_i || clr_i) begin
                    hist_q <= '0;
                    fill_q <= '0;
                    hit_q  <= 1'b0;
                end else if (bit_valid_i) begin
                    hist_q <= window[PAT_LEN-2:0];
                    if (!full) begin
                        fill_q <= fill_q + 1'b1;
                    end
                    hit_q  <= full && (window == PATTERN);
                end else begin
                    hit_q  <= 1'b0;
                end
            end
        end
    endgenerate

    assign hit_o = hit_q;

endmodule

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin scheduler sharing one serial pattern matcher
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset
//   req_i        per-requester request level
//   data_i       word of requester i on data_i[i*DATA_W +: DATA_W]
//   gnt_o        registered one-hot grant, one cycle
//   busy_o       FSM not in IDLE
//   hit_o        matcher output for the previous shifted bit
//   done_o       one-cycle pulse, done_id_o / match_cnt_o valid
//   done_id_o    requester served, held until next done
//   match_cnt_o  matches in served word, held until next done
module seq_detect_sched
    import seq_pkg::*;
#(
    parameter int                 NREQ    = 4,
    parameter int                 DATA_W  = 8,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    localparam int                CNT_W   = $clog2(DATA_W + 1),
    localparam int                ID_W    = $clog2(NREQ)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*DATA_W-1:0] data_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   busy_o,
    output logic                   hit_o,
    output logic                   done_o,
    output logic [ID_W-1:0]        done_id_o,
    output logic [CNT_W-1:0]       match_cnt_o
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      id_q;
    logic [DATA_W-1:0]    word_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NREQ-1:0]      gnt_q;
    logic                 done_q;
    logic [ID_W-1:0]      done_id_q;
    logic [CNT_W-1:0]     match_cnt_q;

    logic [MAX_REQ-1:0]   req_ext;
    logic [ID_W-1:0]      winner;
    logic                 accept;
    logic                 bit_valid;
    logic                 last_bit;
    logic                 hit;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req_i;
    end

    assign winner   = ID_W'(rr_winner(req_ext, int'(rr_ptr_q), NREQ));
    assign last_bit = (bit_cnt_q == BIT_W'(DATA_W - 1));

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req_i) state_d = ST_GRANT;
            ST_GRANT: state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        accept    = (state_q == ST_IDLE) && (|req_i);
        bit_valid = (state_q == ST_SHIFT);
    end

    // Word register, arbiter pointer, bit and match counters, result registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            word_q      <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            gnt_q  <= accept ? (NREQ'(1) << winner) : '0;
            done_q <= (state_q == ST_FLUSH);

            if (accept) begin
                word_q    <= data_i[winner*DATA_W +: DATA_W];
                id_q      <= winner;
                bit_cnt_q <= '0;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(hit);
            end

            // The word shifts left so the bit under test is always the MSB.
            if (state_q == ST_SHIFT) begin
                word_q    <= {word_q[DATA_W-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end

            // The hit from the last bit is visible during FLUSH and is folded
            // into the published count here rather than waiting for cnt_q.
            if (state_q == ST_FLUSH) begin
                done_id_q   <= id_q;
                match_cnt_q <= cnt_q + CNT_W'(hit);
            end

            if (state_q == ST_DONE) begin
                rr_ptr_q <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    bit_pattern_matcher #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clr_i       (accept),
        .bit_valid_i (bit_valid),
        .ser_bit_i   (word_q[DATA_W-1]),
        .hit_o       (hit)
    );

    assign gnt_o       = gnt_q;
    assign hit_o       = hit;
    assign done_o      = done_q;
    assign done_id_o   = done_id_q;
    assign match_cnt_o = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - directed self-checking bench for seq_detect_sched
module tb_seq_detect_sched;

    logic        clk;
    logic        reset_i;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  gnt_o;
    logic        busy_o;
    logic        hit_o;
    logic        done_o;
    logic [1:0]  done_id_o;
    logic [3:0]  match_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detect_sched dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_i       (req_i),
        .data_i      (data_i),
        .gnt_o       (gnt_o),
        .busy_o      (busy_o),
        .hit_o       (hit_o),
        .done_o      (done_o),
        .done_id_o   (done_id_o),
        .match_cnt_o (match_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests one word, drops req after the grant and waits for done.
    // lat is the number of cycles from the grant to done.
    task automatic run_txn(input int id, input logic [7:0] w,
                           output logic [3:0] cnt, output logic [1:0] did,
                           output int lat, output bit ok);
        data_i[id*8 +: 8] = w;
        req_i[id] = 1'b1;
        ok  = 1'b0;
        lat = 0;
        cnt = '0;
        did = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (gnt_o[id]) ok = 1'b1;
        end
        req_i[id] = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 1; i <= 40 && !ok; i++) begin
                tick();
                if (done_o) begin
                    ok  = 1'b1;
                    lat = i;
                end
            end
            cnt = match_cnt_o;
            did = done_id_o;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        req_i   = '0;
        data_i  = '0;
        repeat (3) tick();
        n_checks++;
        if ({gnt_o, busy_o, hit_o, done_o} !== 7'b0)
            $display("FAIL reset_ctrl: got gnt=%b busy=%b hit=%b done=%b expected all 0",
                     gnt_o, busy_o, hit_o, done_o);
        else n_pass++;
        n_checks++;
        if (done_id_o !== 2'd0 || match_cnt_o !== 4'd0)
            $display("FAIL reset_result: got id=%0d cnt=%0d expected 0/0", done_id_o, match_cnt_o);
        else n_pass++;
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [15:0] hit_seen;
        int          done_at;
        int          done_n;
        hit_seen = '0;
        done_at  = 0;
        done_n   = 0;
        data_i[7:0] = 8'b10101010;
        req_i = 4'b0001;
        tick();
        n_checks++;
        if (gnt_o !== 4'b0001 || busy_o !== 1'b1)
            $display("FAIL single_gnt: got gnt=%b busy=%b expected 0001/1", gnt_o, busy_o);
        else n_pass++;
        req_i = 4'b0000;
        for (int n = 1; n <= 14; n++) begin
            tick();
            hit_seen[n] = hit_o;
            if (done_o) begin
                done_n++;
                if (done_at == 0) done_at = n;
            end
            if (n == 1) begin
                n_checks++;
                if (gnt_o !== 4'b0000)
                    $display("FAIL single_gnt_pulse: got gnt=%b expected 0000", gnt_o);
                else n_pass++;
            end
        end
        n_checks++;
        if (hit_seen !== 16'h0150)
            $display("FAIL single_hit_align: got %h expected 0150", hit_seen);
        else n_pass++;
        n_checks++;
        if (done_at !== 10 || done_n !== 1)
            $display("FAIL single_done_time: got at=%0d pulses=%0d expected 10/1", done_at, done_n);
        else n_pass++;
        n_checks++;
        if (match_cnt_o !== 4'd3 || done_id_o !== 2'd0)
            $display("FAIL single_result: got cnt=%0d id=%0d expected 3/0", match_cnt_o, done_id_o);
        else n_pass++;
        n_checks++;
        if (busy_o !== 1'b0)
            $display("FAIL single_idle: got busy=%b expected 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_patterns();
        logic [3:0] cnt;
        logic [1:0] did;
        int         lat;
        bit         ok;
        run_txn(2, 8'b10100101, cnt, did, lat, ok);
        n_checks++;
        if (!ok || cnt !== 4'd2 || did !== 2'd2 || lat !== 10)
            $display("FAIL pat_a5: got ok=%0d cnt=%0d id=%0d lat=%0d expected 1/2/2/10", ok, cnt, did, lat);
        else n_pass++;
        run_txn(2, 8'hFF, cnt, did, lat, ok);
        n_checks++;
        if (!ok || cnt !== 4'd0 || did !== 2'd2)
            $display("FAIL pat_ff: got ok=%0d cnt=%0d id=%0d expected 1/0/2", ok, cnt, did);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int         g_order[5];
        int         d_time[5];
        int         d_id[5];
        int         d_cnt[5];
        int         exp_order[5];
        int         exp_cnt[5];
        int         ng;
        int         nd;
        bit         onehot_ok;
        exp_order = '{0, 1, 2, 3, 0};
        exp_cnt   = '{3, 2, 0, 1, 3};
        ng = 0;
        nd = 0;
        onehot_ok = 1'b1;
        reset_i = 1'b1;
        data_i  = {8'b00000101, 8'hFF, 8'b10100101, 8'b10101010};
        req_i   = 4'b1111;
        repeat (2) tick();
        reset_i = 1'b0;
        for (int n = 0; n < 80 && nd < 5; n++) begin
            tick();
            if (gnt_o !== 4'b0000) begin
                if (!$onehot(gnt_o)) onehot_ok = 1'b0;
                if (ng < 5) begin
                    for (int k = 0; k < 4; k++) if (gnt_o[k]) g_order[ng] = k;
                    ng++;
                end
            end
            if (done_o) begin
                d_time[nd] = n;
                d_id[nd]   = int'(done_id_o);
                d_cnt[nd]  = int'(match_cnt_o);
                nd++;
            end
        end
        req_i = 4'b0000;
        n_checks++;
        if (nd !== 5 || ng !== 5 || !onehot_ok)
            $display("FAIL rr_progress: got dones=%0d grants=%0d onehot=%0d expected 5/5/1", nd, ng, onehot_ok);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i < nd && i < ng) begin
                n_checks++;
                if (g_order[i] !== exp_order[i] || d_id[i] !== exp_order[i] || d_cnt[i] !== exp_cnt[i])
                    $display("FAIL rr_txn%0d: got gnt=%0d id=%0d cnt=%0d expected %0d/%0d/%0d",
                             i, g_order[i], d_id[i], d_cnt[i], exp_order[i], exp_order[i], exp_cnt[i]);
                else n_pass++;
            end
            if (i > 0 && i < nd) begin
                n_checks++;
                if (d_time[i] - d_time[i-1] !== 12)
                    $display("FAIL rr_spacing%0d: got %0d expected 12", i, d_time[i] - d_time[i-1]);
                else n_pass++;
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_no_cross();
        logic [3:0] cnt;
        logic [1:0] did;
        int         lat;
        bit         ok;
        run_txn(0, 8'b00000010, cnt, did, lat, ok);
        n_checks++;
        if (!ok || cnt !== 4'd0 || did !== 2'd0)
            $display("FAIL nocross_w1: got ok=%0d cnt=%0d id=%0d expected 1/0/0", ok, cnt, did);
        else n_pass++;
        run_txn(0, 8'b10000000, cnt, did, lat, ok);
        n_checks++;
        if (!ok || cnt !== 4'd0 || did !== 2'd0)
            $display("FAIL nocross_w2: got ok=%0d cnt=%0d id=%0d expected 1/0/0", ok, cnt, did);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [3:0] cnt;
        logic [1:0] did;
        int         lat;
        bit         ok;
        bit         spurious;
        // Leaves rr_ptr at 3 so a cleared pointer is observable below.
        run_txn(2, 8'h00, cnt, did, lat, ok);
        data_i[23:16] = 8'b01010000;
        req_i = 4'b0100;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (gnt_o[2]) ok = 1'b1;
        end
        req_i = 4'b0000;
        n_checks++;
        if (!ok) $display("FAIL abort_gnt: got no grant expected gnt[2]");
        else n_pass++;
        repeat (4) tick();
        // The 4th SHIFT cycle would complete 101 on bit 3.
        reset_i = 1'b1;
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || hit_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL abort_state: got busy=%b hit=%b done=%b expected 0/0/0", busy_o, hit_o, done_o);
        else n_pass++;
        reset_i = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_o || busy_o) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) $display("FAIL abort_quiet: got activity after reset expected none");
        else n_pass++;
        data_i[15:8]  = 8'b10100101;
        data_i[31:24] = 8'hFF;
        req_i = 4'b1010;
        tick();
        n_checks++;
        if (gnt_o !== 4'b0010)
            $display("FAIL abort_rr_ptr: got gnt=%b expected 0010", gnt_o);
        else n_pass++;
        req_i = 4'b0000;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (done_o) ok = 1'b1;
        end
        n_checks++;
        if (!ok || done_id_o !== 2'd1 || match_cnt_o !== 4'd2)
            $display("FAIL abort_regrant: got ok=%0d id=%0d cnt=%0d expected 1/1/2", ok, done_id_o, match_cnt_o);
        else n_pass++;
    endtask

    task automatic test_drop_req();
        bit ok;
        bit stray;
        data_i[15:8]  = 8'b10101010;
        data_i[31:24] = 8'hFF;
        req_i = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (gnt_o[1]) ok = 1'b1;
        end
        n_checks++;
        if (!ok) $display("FAIL drop_first_gnt: got no grant expected gnt[1]");
        else n_pass++;
        req_i = 4'b1010;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (done_o) ok = 1'b1;
        end
        // req[3] falls during DONE, before IDLE can sample it.
        req_i = 4'b0010;
        stray = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (gnt_o !== 4'b0000) begin
                ok = 1'b1;
                n_checks++;
                if (gnt_o !== 4'b0010)
                    $display("FAIL drop_second_gnt: got gnt=%b expected 0010", gnt_o);
                else n_pass++;
            end
        end
        req_i = 4'b0000;
        n_checks++;
        if (!ok) $display("FAIL drop_second_wait: got no grant expected gnt[1]");
        else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (done_o) ok = 1'b1;
        end
        n_checks++;
        if (!ok || done_id_o !== 2'd1 || match_cnt_o !== 4'd3)
            $display("FAIL drop_result: got ok=%0d id=%0d cnt=%0d expected 1/1/3", ok, done_id_o, match_cnt_o);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt_o !== 4'b0000) stray = 1'b1;
        end
        n_checks++;
        if (stray) $display("FAIL drop_no_gnt3: got a later grant expected none");
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_round_robin();
        test_no_cross();
        test_reset_abort();
        test_drop_req();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that shares one serial bit-pattern matcher among NREQ requesters. Each requester presents a DATA_W-bit word under a req/gnt handshake. The scheduler grants one requester, latches its word and shifts it MSB-first through the matcher. It then returns the overlapping-match count with a one-cycle done pulse and the winner's ID. It sits between the word-level producer blocks and the serial sequence-detection datapath.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DATA_W, 8: word width, bits shifted per transaction.
- PAT_LEN, 3: pattern length, 1..DATA_W.
- PATTERN, 3'b101: pattern to match; MSB is matched first.
- CNT_W, $clog2(DATA_W+1): match counter width (derived, not overridden).
- ID_W, $clog2(NREQ): requester ID width (derived).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- data  in  NREQ*DATA_W  word of requester i on data[i*DATA_W +: DATA_W]; must be stable while req[i] is high.
- gnt  out  NREQ  one-hot grant, registered, high for exactly one cycle.
- busy  out  1  high in every state except IDLE.
- hit  out  1  registered matcher output; serial match seen on the previous shifted bit.
- done  out  1  one-cycle pulse; match_cnt and done_id are valid.
- done_id  out  ID_W  requester served; held until the next done.
- match_cnt  out  CNT_W  matches in the served word; held until the next done.

## Operation
- FSM states: IDLE, GRANT, SHIFT, FLUSH, DONE.
- IDLE
  - If |req, select the winner by round-robin starting at pointer rr_ptr.
  - Latch the winner's data word and ID.
  - Clear the matcher window, bit counter and match counter.
  - Go to GRANT. Otherwise stay in IDLE.
- GRANT: gnt[winner]=1 for this cycle only. Go to SHIFT with bit_cnt=0.
- SHIFT
  - Lasts DATA_W cycles.
  - In cycle k, ser_bit = word[DATA_W-1-k] is presented to the matcher with bit_valid=1.
  - After k=DATA_W-1, go to FLUSH.
- FLUSH
  - One cycle. No bit is presented (bit_valid=0).
  - Lets the hit from the last bit register and be counted.
  - Go to DONE.
- DONE
  - done=1. done_id and match_cnt are updated at entry to this state.
  - rr_ptr <= winner+1, modulo NREQ.
  - Go to IDLE.
- Matcher
  - The window holds the last PAT_LEN valid bits, and a fill counter tracks how many are valid.
  - hit <= bit_valid & (fill >= PAT_LEN-1) & ({window[PAT_LEN-2:0], ser_bit} == PATTERN).
  - Detection overlaps.
  - The window is cleared at the start of each transaction, so a match never spans two words.
- Counter: match counter increments in any cycle with hit=1. It cannot overflow, since the maximum is DATA_W-PAT_LEN+1.
- Requests
  - Not sampled outside IDLE.
  - A req deasserted before IDLE samples it is never granted.
  - After gnt, the requester may drop req or change data. The word is already latched.
  - A req still high after DONE is treated as a new request.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, gnt=0, busy=0, hit=0, done=0, done_id=0, match_cnt=0.
  - Window, fill and counters are all cleared.
- Reset in any state aborts the transaction at the next edge. No done is produced, and the aborted requester must re-request.
- Latency: req sampled at edge E0 in IDLE gives:
  - gnt high in cycle E0..E1.
  - Bits shifted in cycles E1..E(DATA_W+1).
  - FLUSH in the following cycle.
  - done high in cycle E(DATA_W+2)..E(DATA_W+3).
- Throughput: one transaction per DATA_W+4 cycles (12 with defaults), because DONE always returns through IDLE.
- Simultaneous requests: the lowest index at or after rr_ptr (wrapping) wins. Every active requester is served within NREQ transactions.

## Structure
- Package seq_pkg holds:
  - The state enum.
  - Default PATTERN and PAT_LEN constants.
  - A function returning the round-robin winner from req and rr_ptr.
- Sub-module bit_pattern_matcher contains the window, the fill counter and the registered hit. It is parameterized by PAT_LEN and PATTERN and has ports clk, reset, clr, bit_valid, ser_bit, hit.
- The scheduler FSM, arbiter, word register and counter live in seq_detect_sched.

## Test plan
- Case 1: req[0] with data 8'b10101010 after reset -> gnt[0] one cycle, done 10 cycles later, match_cnt=3, done_id=0.
- Case 2: req[2] with data 8'b10100101 -> match_cnt=2. Then 8'hFF -> match_cnt=0.
- Case 3: req=4'b1111 held from reset release -> grant order 0,1,2,3,0, with a done spacing of 12 cycles.
- Case 4: word 8'b00000010 followed by 8'b10000000 from the same requester -> both match_cnt=0, proving no cross-word match.
- Case 5: reset asserted in the 4th SHIFT cycle -> next cycle has busy=0, hit=0, no done, and rr_ptr=0. A new req[1] is granted normally.
- Case 6: req[3] dropped for one cycle before IDLE samples it, while req[1] is held -> only requester 1 is granted. Also check that hit pulses align with the bit positions of the Case 1 pattern.
